// File: rtl/od_pulse_rx.sv
// Receiver for an open-drain, pulse-width-coded single-wire bus: decodes low-pulse widths into
// bits/bytes, pulls the line low briefly to acknowledge each accepted byte.
module od_pulse_rx #(
    parameter int T1_MAX  = 4,
    parameter int T0_MAX  = 12,
    parameter int RST_MIN = 48,
    parameter int ACK_LEN = 6
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       line_in,
    output logic       line_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_err,
    output logic       rx_ovf
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOW       = 2'd1,
        ACK       = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    localparam logic [7:0] T1_W     = 8'(T1_MAX);
    localparam logic [7:0] T0_W     = 8'(T0_MAX);
    localparam logic [7:0] RST_W    = 8'(RST_MIN);
    localparam logic [7:0] ACK_LAST = 8'(ACK_LEN - 1);

    state_t      state_q;
    logic [1:0]  sync_q;
    logic        s_prev_q;
    logic [7:0]  cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  ack_cnt_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        oe_q;
    logic        err_q;
    logic        ovf_q;

    logic        s;
    logic        is_one;
    logic        is_zero;
    logic        is_err;
    logic        got_bit;
    logic        last_bit;
    logic        take;
    logic        can_load;
    logic [7:0]  cnt_d;
    logic [7:0]  shift_d;

    assign s        = sync_q[1];
    assign is_one   = (cnt_q >= 8'd1) && (cnt_q <= T1_W);
    assign is_zero  = (cnt_q > T1_W) && (cnt_q <= T0_W);
    assign is_err   = (cnt_q > T0_W) && (cnt_q < RST_W);
    assign got_bit  = is_one | is_zero;
    assign last_bit = (bit_cnt_q == 3'd7);
    assign take     = valid_q & rx_ready;
    assign can_load = ~valid_q | rx_ready;
    assign cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    // LSB first: each new bit enters at the top and the byte settles into place after eight shifts.
    assign shift_d  = {is_one, shift_q[7:1]};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            s_prev_q  <= 1'b1;
            cnt_q     <= 8'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            ack_cnt_q <= 8'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], line_in};
            s_prev_q <= s;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            if (take) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (s_prev_q && !s) begin
                        cnt_q   <= 8'd1;
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    if (!s) begin
                        cnt_q <= cnt_d;
                    end else begin
                        state_q <= IDLE;
                        if (got_bit) begin
                            if (last_bit) begin
                                bit_cnt_q <= 3'd0;
                                shift_q   <= 8'd0;
                                if (can_load) begin
                                    // Load wins over the consume-clear above in the same cycle.
                                    data_q    <= shift_d;
                                    valid_q   <= 1'b1;
                                    oe_q      <= 1'b1;
                                    ack_cnt_q <= 8'd0;
                                    state_q   <= ACK;
                                end else begin
                                    ovf_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                shift_q   <= shift_d;
                            end
                        end else begin
                            bit_cnt_q <= 3'd0;
                            shift_q   <= 8'd0;
                            err_q     <= is_err;
                        end
                    end
                end
                ACK: begin
                    // Our own pull-down is on the line here, so the line level is not decoded.
                    if (ack_cnt_q == ACK_LAST) begin
                        oe_q    <= 1'b0;
                        state_q <= WAIT_HIGH;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 8'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign line_oe  = oe_q;
    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_err   = err_q;
    assign rx_ovf   = ovf_q;

endmodule

// File: tb/tb_od_pulse_rx.sv
// Directed bench for od_pulse_rx: a bus master drives low pulses onto a wired-AND line model.
module tb_od_pulse_rx;

    localparam int W1  = 3;
    localparam int W0  = 10;
    localparam int GAP = 5;

    logic       clk;
    logic       clrn;
    logic       line_in;
    logic       line_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_err;
    logic       rx_ovf;
    logic       master_low;

    int checks = 0;
    int fails  = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int valid_cycles = 0;
    int oe_run = 0;
    int last_oe_run = 0;
    int ack_cnt = 0;

    logic       snap_valid;
    logic [7:0] snap_data;
    logic       snap_oe;

    int e0, o0, a0, v0;

    od_pulse_rx dut (
        .clk      (clk),
        .clrn     (clrn),
        .line_in  (line_in),
        .line_oe  (line_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_err   (rx_err),
        .rx_ovf   (rx_ovf)
    );

    assign line_in = ~(master_low | line_oe);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_err)   err_cnt <= err_cnt + 1;
        if (rx_ovf)   ovf_cnt <= ovf_cnt + 1;
        if (rx_valid) valid_cycles <= valid_cycles + 1;
        if (line_oe) begin
            oe_run <= oe_run + 1;
        end else if (oe_run != 0) begin
            last_oe_run <= oe_run;
            ack_cnt     <= ack_cnt + 1;
            oe_run      <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_pulse(input int low, input int gap);
        master_low = 1'b1;
        repeat (low) @(posedge clk);
        #1 master_low = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    // The ready pulse lands on the cycle the 8th bit is decoded: release + sync(2) + decode.
    task automatic send_byte(input logic [7:0] b, input bit ready_pulse);
        for (int i = 0; i < 7; i++) send_pulse(b[i] ? W1 : W0, GAP);
        master_low = 1'b1;
        repeat (b[7] ? W1 : W0) @(posedge clk);
        #1 master_low = 1'b0;
        if (ready_pulse) begin
            @(posedge clk);
            @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1;
            snap_valid = rx_valid;
            snap_data  = rx_data;
            snap_oe    = line_oe;
            rx_ready   = 1'b0;
        end
        repeat (25) @(posedge clk);
        #1;
    endtask

    initial begin
        int bw[8];
        clrn = 1'b0;
        master_low = 1'b0;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data",  32'(rx_data),  32'h00);
        chk("rst_valid", 32'(rx_valid), 32'h0);
        chk("rst_oe",    32'(line_oe),  32'h0);
        chk("rst_err",   32'(rx_err),   32'h0);
        chk("rst_ovf",   32'(rx_ovf),   32'h0);
        clrn = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 0xA5 with consumer always ready
        v0 = valid_cycles;
        send_byte(8'hA5, 1'b0);
        chk("a5_data",   32'(rx_data), 32'hA5);
        chk("a5_vcyc",   32'(valid_cycles - v0), 32'd1);
        chk("a5_oelen",  32'(last_oe_run), 32'd6);
        chk("a5_acks",   32'(ack_cnt), 32'd1);
        chk("a5_noerr",  32'(err_cnt), 32'd0);

        // boundary widths 4/5/12 decode as 1/0/0 -> bits 1,0,0,1,1,1,1,1 = 0xF9
        bw = '{4, 5, 12, 4, 4, 4, 4, 4};
        for (int i = 0; i < 8; i++) send_pulse(bw[i], (i == 7) ? 25 : GAP);
        chk("bnd_data",  32'(rx_data), 32'hF9);
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) send_pulse(W1, GAP);
        send_pulse(13, GAP);
        chk("bnd_13err", 32'(err_cnt - e0), 32'd1);
        send_pulse(47, GAP);
        chk("bnd_47err", 32'(err_cnt - e0), 32'd2);
        for (int i = 0; i < 2; i++) send_pulse(W1, GAP);
        send_pulse(48, GAP);
        chk("bnd_48ok",  32'(err_cnt - e0), 32'd2);
        send_byte(8'h5A, 1'b0);
        chk("bnd_resync", 32'(rx_data), 32'h5A);

        // bus reset mid-byte, then 0x3C
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) send_pulse(W0, GAP);
        send_pulse(60, GAP);
        send_byte(8'h3C, 1'b0);
        chk("rst60_data", 32'(rx_data), 32'h3C);
        chk("rst60_err",  32'(err_cnt - e0), 32'd0);

        // overflow: consumer stalled
        rx_ready = 1'b0;
        send_byte(8'h11, 1'b0);
        chk("ovf_first",  32'(rx_data), 32'h11);
        chk("ovf_valid",  32'(rx_valid), 32'h1);
        a0 = ack_cnt;
        o0 = ovf_cnt;
        send_byte(8'h22, 1'b0);
        chk("ovf_hold",   32'(rx_data), 32'h11);
        chk("ovf_pulse",  32'(ovf_cnt - o0), 32'd1);
        chk("ovf_noack",  32'(ack_cnt - a0), 32'd0);
        chk("ovf_vstay",  32'(rx_valid), 32'h1);

        // consume and reload in the same cycle
        a0 = ack_cnt;
        o0 = ovf_cnt;
        send_byte(8'h22, 1'b1);
        chk("same_valid", 32'(snap_valid), 32'h1);
        chk("same_data",  32'(snap_data), 32'h22);
        chk("same_oe",    32'(snap_oe), 32'h1);
        chk("same_noovf", 32'(ovf_cnt - o0), 32'd0);
        chk("same_ack",   32'(ack_cnt - a0), 32'd1);

        // reset pulse inside bit 5 (still holding 0x22 unconsumed)
        e0 = err_cnt;
        for (int i = 0; i < 4; i++) send_pulse(W1, GAP);
        master_low = 1'b1;
        repeat (9) @(posedge clk);
        #1 clrn = 1'b0;
        #1;
        chk("mid_data",  32'(rx_data), 32'h00);
        chk("mid_valid", 32'(rx_valid), 32'h0);
        chk("mid_oe",    32'(line_oe), 32'h0);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        master_low = 1'b0;
        repeat (10) @(posedge clk);
        #1 rx_ready = 1'b1;
        send_byte(8'h7E, 1'b0);
        chk("mid_7e",    32'(rx_data), 32'h7E);
        chk("mid_noerr", 32'(err_cnt - e0), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/od_pulse_rx.md
OD_PULSE_RX -- requirements
Module: od_pulse_rx

Interface
REQ-001 SHALL have parameter T1_MAX, default 4: longest low pulse, in cycles, decoded as bit 1.
REQ-002 SHALL have parameter T0_MAX, default 12: longest low pulse, in cycles, decoded as bit 0.
REQ-003 SHALL have parameter RST_MIN, default 48: shortest low pulse, in cycles, treated as a bus reset; legal range T0_MAX < RST_MIN <= 255.
REQ-004 SHALL have parameter ACK_LEN, default 6: number of cycles the acknowledge pull-down is held.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port clrn, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port line_in, input, 1 bit: resolved level of the wired open-drain bus; a released (z) bus reads 1.
REQ-008 SHALL have port line_oe, output, 1 bit: 1 means the external pad pulls the bus to 0; 0 means the pad releases the bus to z.
REQ-009 SHALL have port rx_data, output, 8 bits: last accepted byte.
REQ-010 SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-011 SHALL have port rx_ready, input, 1 bit: consumer takes the byte in any cycle where rx_valid & rx_ready.
REQ-012 SHALL have port rx_err, output, 1 bit: one-cycle pulse on a framing error.
REQ-013 SHALL have port rx_ovf, output, 1 bit: one-cycle pulse when a completed byte is dropped.

Function
REQ-014 SHALL pass line_in through a 2-flop synchronizer; s denotes the synchronizer output.
REQ-015 SHALL implement states IDLE, LOW, ACK and WAIT_HIGH.
REQ-016 IDLE: on s falling (previous s = 1, current s = 0), SHALL load cnt = 1 and enter LOW; otherwise SHALL stay in IDLE.
REQ-017 LOW: SHALL increment cnt each cycle s = 0, 8-bit, saturating at 255.
REQ-018 LOW, first cycle s = 1, with w = cnt: 1 <= w <= T1_MAX SHALL shift in bit 1; T1_MAX < w <= T0_MAX SHALL shift in bit 0; T0_MAX < w < RST_MIN SHALL pulse rx_err and clear bit count and shift register; w >= RST_MIN SHALL clear bit count and shift register without rx_err.
REQ-019 In each of the REQ-018 cases, SHALL return to IDLE unless a byte completes.
REQ-020 Bits SHALL be received LSB first into an 8-bit shift register with a 3-bit bit counter.
REQ-021 On the 8th bit with (rx_valid = 0 or rx_ready = 1) in that cycle: next cycle rx_data = byte, rx_valid = 1, line_oe = 1, state = ACK.
REQ-022 On the 8th bit with rx_valid = 1 and rx_ready = 0: byte dropped, rx_ovf = 1 for one cycle, no acknowledge, rx_data unchanged, state = IDLE.
REQ-023 After every 8th bit, whether accepted or dropped, bit count and shift register SHALL clear.
REQ-024 ACK: line_oe SHALL be held 1 for exactly ACK_LEN cycles, then 0, then state = WAIT_HIGH.
REQ-025 ACK: s SHALL be ignored, since the block's own pull-down is not decoded as a bit.
REQ-026 WAIT_HIGH: SHALL enter IDLE on the first cycle s = 1; falling edges SHALL NOT be detected before that.
REQ-027 rx_valid SHALL clear in the cycle after rx_valid & rx_ready, unless a new byte loads in that same cycle (REQ-021), in which case it stays 1.
REQ-028 rx_data SHALL stay stable while rx_valid = 1.
REQ-029 line_oe SHALL be 1 only in ACK; the bus is otherwise never driven.

Reset
REQ-030 clrn = 0 SHALL immediately set: synchronizer = 2'b11, state = IDLE, cnt = 0, bit count = 0, shift register = 0, rx_data = 8'h00, rx_valid = 0, line_oe = 0, rx_err = 0, rx_ovf = 0.
REQ-031 Reset mid-byte or mid-ACK SHALL discard the partial byte and release the bus; decoding SHALL restart from IDLE after clrn rises.

Verification
REQ-032 Bit 1 = low 3 cycles, bit 0 = low 10 cycles, high gaps 5 cycles; send 0xA5 with rx_ready = 1 -> rx_data = 0xA5, rx_valid one cycle, line_oe high exactly 6 cycles.
REQ-033 Boundary widths 4 / 5 / 12 / 13 / 47 / 48 -> bit 1 / bit 0 / bit 0 / rx_err / rx_err / silent resync (no rx_err).
REQ-034 3 bits, then a 60-cycle low, then 0x3C -> rx_data = 0x3C with no rx_err.
REQ-035 rx_ready = 0; send 0x11 then 0x22 -> rx_data stays 0x11, rx_ovf pulses once, no line_oe for the second byte.
REQ-036 rx_ready pulsed in the same cycle the 8th bit of 0x22 completes while 0x11 is pending -> rx_valid stays 1, rx_data = 0x22, acknowledge driven.
REQ-037 clrn low for 1 cycle during bit 5 of a byte, then a full 0x7E -> outputs at reset values during reset, then rx_data = 0x7E.
